cgra_axi_read_stream: RTL

//  Downstream stage of the CGRA AXI read-address generator. Consumes AXI R-channel beats for a

---
 rtl/cgra_axi_read_stream_if.sv | 30 +++
 rtl/cgra_axi_read_stream.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cgra_axi_read_stream_if.sv
// AR-credit, AXI R-channel and CGRA stream signals of the CGRA AXI read-stream stage.
// The slave modport is the stage's view; master is the upstream/downstream environment.
interface cgra_axi_read_stream_if #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int LANE_W         = 1
);
    logic                      ar_hs_i;
    logic [LANE_W-1:0]         ar_lane_i;
    logic                      ar_credit_o;
    logic [AXI_ID_WIDTH-1:0]   r_id_i;
    logic [AXI_DATA_WIDTH-1:0] r_data_i;
    logic [1:0]                r_resp_i;
    logic                      r_last_i;
    logic                      r_valid_i;
    logic                      r_ready_o;
    logic [31:0]               data_o;
    logic                      valid_o;
    logic                      ready_i;

    modport master (
        output ar_hs_i, ar_lane_i, r_id_i, r_data_i, r_resp_i, r_last_i, r_valid_i, ready_i,
        input  ar_credit_o, r_ready_o, data_o, valid_o
    );

    modport slave (
        input  ar_hs_i, ar_lane_i, r_id_i, r_data_i, r_resp_i, r_last_i, r_valid_i, ready_i,
        output ar_credit_o, r_ready_o, data_o, valid_o
    );
endinterface

// File: rtl/cgra_axi_read_stream.sv
// Receives single-beat AXI reads of a strided load, extracts the addressed 32-bit lane and
// streams the words to a CGRA node; AR credit guarantees a FIFO slot for every issued read.
module cgra_axi_read_stream #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int FIFO_DEPTH     = 8,
    parameter int LANE_W         = (AXI_DATA_WIDTH / 32 > 1) ? $clog2(AXI_DATA_WIDTH / 32) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [15:0]           num_beats_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    cgra_axi_read_stream_if.slave bus
);
    localparam int NUM_LANES = AXI_DATA_WIDTH / 32;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_WIDE = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e              r_state, w_state_next;
    logic [15:0]         r_num_beats, r_iss_cnt, r_rcv_cnt, w_rcv_next;
    logic [CNT_W-1:0]    r_outstanding, r_fifo_cnt, w_fifo_cnt_next;
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr, r_lq_wr_ptr, r_lq_rd_ptr;
    logic [31:0]         r_fifo_mem [FIFO_DEPTH];
    logic [LANE_W-1:0]   r_lane_mem [FIFO_DEPTH];
    logic                r_err;
    logic                w_start, w_r_hs, w_pop, w_full, w_empty, w_credit, w_r_ready;
    logic [CNT_W:0]      w_inflight;
    logic [LANE_W-1:0]   w_lane;
    logic [31:0]         w_word;
    logic [AXI_ID_WIDTH-1:0] w_unused_id;
    logic                w_unused_last;

    // Single-ID, single-beat traffic: ID and LAST carry no information here.
    assign w_unused_id   = bus.r_id_i;
    assign w_unused_last = bus.r_last_i;

    assign w_start    = start_i && (r_state == S_IDLE);
    assign w_full     = (r_fifo_cnt == DEPTH_C);
    assign w_empty    = (r_fifo_cnt == '0);
    assign w_pop      = !w_empty && bus.ready_i;
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
    assign w_credit   = (r_state == S_RUN) && (r_iss_cnt < r_num_beats) && (w_inflight < DEPTH_WIDE);
    assign w_r_ready  = ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                        (r_outstanding != '0) && !w_full;
    assign w_r_hs     = bus.r_valid_i && w_r_ready;
    assign w_rcv_next = r_rcv_cnt + {15'd0, w_r_hs};
    assign w_lane     = r_lane_mem[r_lq_rd_ptr];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_word = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (w_lane == LANE_W'(l)) w_word = bus.r_data_i[32*l +: 32];
        end
    end

    always_comb begin
        w_fifo_cnt_next = r_fifo_cnt;
        case ({w_r_hs, w_pop})
            2'b10:   w_fifo_cnt_next = r_fifo_cnt + CNT_W'(1);
            2'b01:   w_fifo_cnt_next = r_fifo_cnt - CNT_W'(1);
            default: w_fifo_cnt_next = r_fifo_cnt;
        endcase
    end

    // Next-state looks at post-edge counts so DONE follows the last pop by one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_next = (num_beats_i != 16'd0) ? S_RUN : S_DONE;
            S_RUN:   if (w_rcv_next == r_num_beats) w_state_next = S_DRAIN;
            S_DRAIN: if (w_fifo_cnt_next == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_num_beats   <= '0;
            r_iss_cnt     <= '0;
            r_rcv_cnt     <= '0;
            r_err         <= 1'b0;
            r_outstanding <= '0;
        end else begin
            if (w_start) begin
                r_num_beats <= num_beats_i;
                r_iss_cnt   <= '0;
                r_rcv_cnt   <= '0;
                r_err       <= 1'b0;
            end else begin
                r_iss_cnt <= r_iss_cnt + {15'd0, bus.ar_hs_i};
                r_rcv_cnt <= w_rcv_next;
                if (w_r_hs && (bus.r_resp_i != 2'b00)) r_err <= 1'b1;
            end
            case ({bus.ar_hs_i, w_r_hs})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fifo_cnt  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_lq_wr_ptr <= '0;
            r_lq_rd_ptr <= '0;
        end else begin
            r_fifo_cnt <= w_fifo_cnt_next;
            if (w_r_hs)      r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
            if (w_pop)       r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
            if (bus.ar_hs_i) r_lq_wr_ptr <= r_lq_wr_ptr + PTR_W'(1);
            if (w_r_hs)      r_lq_rd_ptr <= r_lq_rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: storage arrays are not reset; pointers and counts alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (w_r_hs)      r_fifo_mem[r_wr_ptr]    <= w_word;
        if (bus.ar_hs_i) r_lane_mem[r_lq_wr_ptr] <= bus.ar_lane_i;
    end

    assign bus.ar_credit_o = w_credit;
    assign bus.r_ready_o   = w_r_ready;
    assign bus.valid_o     = !w_empty;
    assign bus.data_o      = w_empty ? 32'd0 : r_fifo_mem[r_rd_ptr];
    assign busy_o          = (r_state != S_IDLE);
    assign done_o          = (r_state == S_DONE);
    assign err_o           = r_err;

    // Upstream must hold off while credit is withheld; counters still track the extra read.
    a_ar_hs_needs_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.ar_hs_i |-> w_credit);
endmodule
